// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial unsigned subtractor, diff = a - b (mod 2^WIDTH), processed
//   LSB first at one bit per clock. Trades latency for a one-bit datapath.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   a/b operand pair is valid
//   in_ready   block can accept operands (high only in IDLE)
//   a, b       minuend / subtrahend, unsigned
//   out_valid  diff/borrow are valid (high only in DONE)
//   out_ready  consumer accepts the result
//   diff       (a - b) mod 2^WIDTH, holds last completed result
//   borrow     1 when a < b, registered together with diff
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer keeps payload stable while valid is high and not
// yet accepted. in_ready and out_valid are registered and depend only on the
// FSM state, so neither channel has a combinational path to the other.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_next;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             d_bit;
  logic             br_next;
  logic             last_bit;

  // One full-subtractor bit slice working on the operand LSBs.
  always_comb begin
    d_bit    = a_sh[0] ^ b_sh[0] ^ br;
    br_next  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    // Result bits enter at the MSB so that after WIDTH shifts the first
    // (LSB) difference bit has reached position 0.
    res_next = res >> 1;
    res_next[WIDTH-1] = d_bit;
    last_bit = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      diff      <= '0;
      borrow    <= 1'b0;
      cnt       <= '0;
      br        <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      res       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh     <= a;
            b_sh     <= b;
            cnt      <= '0;
            br       <= 1'b0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          res  <= res_next;
          br   <= br_next;
          cnt  <= cnt + 1'b1;
          if (last_bit) begin
            // Publish the finished result straight from the bit slice so
            // diff/borrow are already valid on the first DONE cycle.
            diff      <= res_next;
            borrow    <= br_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Directed bench for serial_subtractor (WIDTH=4): reset values, latency,
//   borrow cases, backpressure, back-to-back throughput, mid-RUN reset and an
//   all-pairs sweep with random output stalls.
module tb_serial_subtractor;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [WIDTH-1:0] exp_q[$];

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full operation: accept, wait for result, stall, retire.
  task automatic run_op(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b,
                        input int stall, input string tag);
    logic [WIDTH-1:0] exp_d;
    logic             exp_b;
    int               lat;
    exp_d = op_a - op_b;
    exp_b = (op_a < op_b);
    lat = 0;
    while (!in_ready && lat < 20) begin
      step();
      lat++;
    end
    check({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    a         = op_a;
    b         = op_b;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    a = WIDTH'($urandom_range(0, 15));
    b = WIDTH'($urandom_range(0, 15));
    check({tag, " in_ready after accept"}, 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(WIDTH));
    exp_q.push_back(exp_d);
    check({tag, " diff"}, 32'(diff), 32'(exp_q.pop_front()));
    check({tag, " borrow"}, 32'(borrow), 32'(exp_b));
    for (int i = 0; i < stall; i++) begin
      step();
      check({tag, " stall out_valid"}, 32'(out_valid), 32'd1);
      check({tag, " stall diff"}, 32'(diff), 32'(exp_d));
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, " out_valid after retire"}, 32'(out_valid), 32'd0);
    check({tag, " in_ready after retire"}, 32'(in_ready), 32'd1);
  endtask

  initial begin : stim
    int t_rise[3];
    int lat;
    logic [WIDTH-1:0] ops_a[3];
    logic [WIDTH-1:0] ops_b[3];
    logic [WIDTH-1:0] res_d[3];
    logic             res_b[3];

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    step();
    step();
    rst_n = 1'b1;
    check("reset in_ready",  32'(in_ready),  32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset diff",      32'(diff),      32'd0);
    check("reset borrow",    32'(borrow),    32'd0);

    // Basic directed vectors
    run_op(4'd9,  4'd3,  0, "9-3");
    run_op(4'd3,  4'd9,  0, "3-9");
    run_op(4'd0,  4'd1,  0, "0-1");
    run_op(4'd15, 4'd15, 1, "15-15");
    run_op(4'd0,  4'd0,  0, "0-0");

    // Backpressure: result 7 held while new operands are offered
    in_valid = 1'b1; a = 4'd12; b = 4'd5; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    check("bp latency", 32'(lat), 32'd4);
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; a = 4'd1; b = 4'd1;
      step();
      check("bp out_valid", 32'(out_valid), 32'd1);
      check("bp diff",      32'(diff),      32'd7);
      check("bp in_ready",  32'(in_ready),  32'd0);
    end
    in_valid  = 1'b0;
    check("bp diff before retire", 32'(diff), 32'd7);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp retire out_valid", 32'(out_valid), 32'd0);
    step();
    step();
    check("bp 1-1 not accepted in_ready", 32'(in_ready),  32'd1);
    check("bp 1-1 not accepted out_valid", 32'(out_valid), 32'd0);
    check("bp diff held",                 32'(diff),      32'd7);

    // Back-to-back with in_valid and out_ready held high
    ops_a[0] = 4'd10; ops_b[0] = 4'd4;  res_d[0] = 4'd6;  res_b[0] = 1'b0;
    ops_a[1] = 4'd4;  ops_b[1] = 4'd10; res_d[1] = 4'hA;  res_b[1] = 1'b1;
    ops_a[2] = 4'd8;  ops_b[2] = 4'd8;  res_d[2] = 4'd0;  res_b[2] = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    a = ops_a[0]; b = ops_b[0];
    for (int i = 0; i < 3; i++) begin
      lat = 0;
      while (!out_valid && lat < 20) begin
        step();
        lat++;
      end
      t_rise[i] = cyc;
      check($sformatf("b2b %0d out_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("b2b %0d diff", i),      32'(diff),      32'(res_d[i]));
      check($sformatf("b2b %0d borrow", i),    32'(borrow),    32'(res_b[i]));
      if (i < 2) begin
        a = ops_a[i+1];
        b = ops_b[i+1];
      end
      step();
    end
    in_valid = 1'b0;
    check("b2b period 0-1", 32'(t_rise[1] - t_rise[0]), 32'd6);
    check("b2b period 1-2", 32'(t_rise[2] - t_rise[1]), 32'd6);
    out_ready = 1'b0;
    for (int i = 0; i < 8 && !in_ready; i++) step();
    // Flush any operation started by the held in_valid
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
    out_ready = 1'b0;
    check("b2b drained in_ready", 32'(in_ready), 32'd1);

    // Reset on the second RUN cycle of 7-2
    in_valid = 1'b1; a = 4'd7; b = 4'd2;
    step();
    in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("abort in_ready",  32'(in_ready),  32'd1);
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort diff",      32'(diff),      32'd0);
    check("abort borrow",    32'(borrow),    32'd0);
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid) lat++;
    end
    check("abort no result", 32'(lat), 32'd0);
    run_op(4'd7, 4'd2, 0, "7-2 after abort");

    // All pairs with random output stalls
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        run_op(WIDTH'(i), WIDTH'(j), $urandom_range(0, 2), $sformatf("sweep %0d-%0d", i, j));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time limit
  initial begin
    #2000000;
    n_tests++;
    n_fail++;
    $display("FAIL timeout: observed running expected finished");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

endmodule
